// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: widths matching the
// 8x16 register file, the number of registers walked, and the FSM state type.
package regfile_dump_reader_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    // CSUM is only reachable when the checksum word is enabled.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        HOLD = 3'd2,
        DONE = 3'd3,
        CSUM = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Stream interface carrying dumped register words to the downstream consumer.
//
// Handshake: a word transfers on a rising clk edge where dout_valid and
// dout_ready are both high. Once dout_valid rises it stays high, with dout,
// dout_addr and dout_last unchanged, until that transfer happens. dout_ready
// is ignored while dout_valid is low.
interface regfile_dump_reader_if;
    import regfile_dump_reader_pkg::*;

    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_addr;
    logic              dout_last;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_addr,
        output dout_last,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_addr,
        input  dout_last,
        input  dout_valid,
        output dout_ready
    );

endinterface

// File: rtl/regfile_dump_reader_dump_out_reg.sv
// Output holding register for the dump stream: captures one word on load and
// keeps it presented until the downstream handshake consumes it.
module regfile_dump_reader_dump_out_reg
    import regfile_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     load_data,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic                  load_last,
    output logic                  accept,
    regfile_dump_reader_if.master dump
);

    assign accept = dump.dout_valid & dump.dout_ready;

    // Load raises valid; a handshake drops it; otherwise everything holds.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dump.dout       <= '0;
            dump.dout_addr  <= '0;
            dump.dout_last  <= 1'b0;
            dump.dout_valid <= 1'b0;
        end else if (load) begin
            dump.dout       <= load_data;
            dump.dout_addr  <= load_addr;
            dump.dout_last  <= load_last;
            dump.dout_valid <= 1'b1;
        end else if (accept) begin
            dump.dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer for the 8x16 register file. A start pulse walks read
// addresses 0..NUM_REGS-1 through one combinational read port and streams
// each captured word out over a valid/ready interface, 2 cycles per word.
//
// Optional feature macro: DUMP_CHECKSUM_EN. When defined, a running XOR of
// the captured words is appended as one extra word (dout_addr=0, last=1).
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output state_t                fsm_state,
    regfile_dump_reader_if.master dump
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              load;
    logic              accept;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W-1:0] load_addr;
    logic              load_last;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // idx returns to 0 when a dump ends, so the read port idles at address 0.
    assign rd_addr   = idx;
    assign fsm_state = state;

    // Select what the output register captures: a register word, or the checksum.
    always_comb begin
        load      = (state == READ);
        load_data = rd_data;
        load_addr = idx;
`ifdef DUMP_CHECKSUM_EN
        load_last = 1'b0;
        if (state == CSUM) begin
            load      = 1'b1;
            load_data = csum;
            load_addr = '0;
            load_last = 1'b1;
        end
`else
        load_last = (idx == LAST_IDX);
`endif
    end

    // Dump sequencer: state, address counter and the busy/done flags.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        idx   <= '0;
                        busy  <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                READ: begin
                    state <= HOLD;
`ifdef DUMP_CHECKSUM_EN
                    csum  <= csum ^ rd_data;
`endif
                end
                HOLD: begin
                    if (accept) begin
                        // The word just accepted carries last: the dump is over.
                        if (dump.dout_last) begin
                            state <= DONE;
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        end else if (idx == LAST_IDX) begin
                            state <= CSUM;
                            idx   <= '0;
`endif
                        end else begin
                            state <= READ;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                CSUM: state <= HOLD;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    regfile_dump_reader_dump_out_reg u_out_reg (
        .clk       (clk),
        .clr_n     (clr_n),
        .load      (load),
        .load_data (load_data),
        .load_addr (load_addr),
        .load_last (load_last),
        .accept    (accept),
        .dump      (dump)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a table of dump scenarios
// plus hand-written reset / held-start sequences, with a stream scoreboard.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int W = ADDR_W + 1 + DATA_W;  // {addr, last, data}
`ifdef DUMP_CHECKSUM_EN
    localparam int FULL_LAT = 2 * NUM_REGS + 3;
`else
    localparam int FULL_LAT = 2 * NUM_REGS + 1;
`endif

    typedef struct {
        logic [DATA_W-1:0] vals [NUM_REGS];
        int                ready_mode;  // 0 always, 1 toggle, 2 random
        int                restart_at;  // extra start after N handshakes, -1 none
        int                write_at;    // write reg 7 after N handshakes, -1 none
        int                exp_lat;     // start-to-done cycles, -1 unchecked
    } vec_t;

    logic              clk;
    logic              clr_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    state_t            fsm_state;
    regfile_dump_reader_if dif ();

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [W-1:0]      exp_q [$];
    int tests, fails;
    int cyc, start_cyc, done_cyc, done_count, hs_count;
    logic          stall_prev;
    logic [W:0]    held;
    vec_t          vecs [8];

    assign rd_data = mem[rd_addr];

    regfile_dump_reader dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .fsm_state (fsm_state),
        .dump      (dif.master)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the words a dump of mem must produce, in order.
    function automatic void build_exp();
        logic [DATA_W-1:0] x;
        x = '0;
        exp_q.delete();
        for (int a = 0; a < NUM_REGS; a++) begin
            x ^= mem[a];
`ifdef DUMP_CHECKSUM_EN
            exp_q.push_back({ADDR_W'(a), 1'b0, mem[a]});
`else
            exp_q.push_back({ADDR_W'(a), (a == NUM_REGS - 1), mem[a]});
`endif
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back({ADDR_W'(0), 1'b1, x});
`endif
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge.
    initial stall_prev = 1'b0;
    always @(negedge clk) begin
        if (clr_n) begin
            if (stall_prev) begin
                check("stall_hold", 32'({dif.dout_valid, dif.dout_addr, dif.dout_last, dif.dout}), 32'(held));
            end
            if (dif.dout_valid && dif.dout_ready) begin
                hs_count++;
                check("busy_during_word", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'({dif.dout_addr, dif.dout_last, dif.dout}), 32'hFFFFFFFF);
                end else begin
                    check("word", 32'({dif.dout_addr, dif.dout_last, dif.dout}), 32'(exp_q.pop_front()));
                end
            end
            stall_prev = dif.dout_valid && !dif.dout_ready;
            held       = {dif.dout_valid, dif.dout_addr, dif.dout_last, dif.dout};
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd0);
                check("words_left_at_done", 32'(exp_q.size()), 32'd0);
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(dif.dout_valid), 32'd0);
        check({tag, "_raddr"}, 32'(rd_addr), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    // Driver: run one table scenario from start to done.
    task automatic run_vec(input vec_t v, input int id);
        int  n;
        bit  restarted, written;
        restarted = 0;
        written   = 0;
        for (int a = 0; a < NUM_REGS; a++) mem[a] = v.vals[a];
        build_exp();
        hs_count   = 0;
        done_count = 0;
        @(posedge clk); #1;
        start          = 1'b1;
        start_cyc      = cyc;
        dif.dout_ready = (v.ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        while (done_count == 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (!restarted && v.restart_at >= 0 && hs_count == v.restart_at) begin
                start     = 1'b1;
                restarted = 1;
            end
            if (!written && v.write_at >= 0 && hs_count == v.write_at) begin
                mem[NUM_REGS-1] = 16'($urandom);
                build_exp();
                repeat (hs_count) void'(exp_q.pop_front());
                written = 1;
            end
            case (v.ready_mode)
                0:       dif.dout_ready = 1'b1;
                1:       dif.dout_ready = ~dif.dout_ready;
                default: dif.dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
        check($sformatf("v%0d_done_seen", id), 32'(done_count > 0), 32'd1);
        if (v.exp_lat >= 0 && done_count > 0)
            check($sformatf("v%0d_latency", id), 32'(done_cyc - start_cyc), 32'(v.exp_lat));
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("v%0d_done_once", id), 32'(done_count), 32'd1);
        check($sformatf("v%0d_words_left", id), 32'(exp_q.size()), 32'd0);
        check_idle($sformatf("v%0d_idle", id));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DATA_W-1:0] pre [NUM_REGS];
        int n;
        tests = 0;
        fails = 0;
        done_count = 0;
        hs_count = 0;
        pre = '{16'h12, 16'h34, 16'h56, 16'h78, 16'h9A, 16'hBC, 16'hDE, 16'hF0};

        // Scenario table
        vecs[0] = '{vals: pre, ready_mode: 0, restart_at: -1, write_at: -1, exp_lat: FULL_LAT};
        vecs[1] = '{vals: pre, ready_mode: 1, restart_at: -1, write_at: -1, exp_lat: -1};
        vecs[2] = '{vals: pre, ready_mode: 0, restart_at: 3,  write_at: -1, exp_lat: FULL_LAT};
        for (int i = 3; i < 8; i++) begin
            for (int a = 0; a < NUM_REGS; a++) vecs[i].vals[a] = 16'($urandom);
            vecs[i].ready_mode = (i == 3) ? 0 : 2;
            vecs[i].restart_at = -1;
            vecs[i].write_at   = (i >= 6) ? 2 : -1;
            vecs[i].exp_lat    = (i == 3) ? FULL_LAT : -1;
        end

        // Reset block
        for (int a = 0; a < NUM_REGS; a++) mem[a] = '0;
        clr_n = 1'b0;
        start = 1'b0;
        dif.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout",  32'(dif.dout), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        check_idle("reset");
        clr_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // start held high through the whole dump and the DONE cycle
        for (int a = 0; a < NUM_REGS; a++) mem[a] = pre[a];
        build_exp();
        done_count = 0;
        @(posedge clk); #1;
        start = 1'b1;
        dif.dout_ready = 1'b1;
        n = 0;
        while (done_count == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("held_done_seen", 32'(done_count), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("held_done_once", 32'(done_count), 32'd1);
        check_idle("held_idle");

        // Asynchronous reset in the middle of word 4
        build_exp();
        hs_count = 0;
        done_count = 0;
        @(posedge clk); #1;
        start = 1'b1;
        n = 0;
        while (hs_count < 4 && n < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("rst_reached_word4", 32'(hs_count), 32'd4);
        #2;
        clr_n = 1'b0;
        #1;
        check("rst_dout",      32'(dif.dout), 32'd0);
        check("rst_dout_addr", 32'(dif.dout_addr), 32'd0);
        check("rst_dout_last", 32'(dif.dout_last), 32'd0);
        check("rst_done",      32'(done), 32'd0);
        check_idle("rst");
        exp_q.delete();
        for (int a = 0; a < NUM_REGS; a++) mem[a] = '0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_count), 32'd0);

        // All-zero register file after reset: fresh dump from address 0
        begin
            vec_t z;
            for (int a = 0; a < NUM_REGS; a++) z.vals[a] = '0;
            z.ready_mode = 0;
            z.restart_at = -1;
            z.write_at   = -1;
            z.exp_lat    = FULL_LAT;
            run_vec(z, 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
